// File: rtl/approx_mult_seq.sv
// Sequential shift-add unsigned multiplier, one partial-product row per cycle.
// Approximate mode OR-merges the low APPROX_COLS columns with no carry out.
module approx_mult_seq #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               result_approx,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam int K  = APPROX_COLS;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic           mode_reg;
    logic [PW-1:0]  acc;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  res_q;
    logic           res_ap_q;

    logic [PW-1:0]  pp;
    logic [PW-1:0]  sum_ex;
    logic [PW-1:0]  sum_ap;
    logic [PW-1:0]  acc_next;

    assign pp     = b_reg[cnt] ? ({{WIDTH{1'b0}}, a_reg} << cnt) : '0;
    assign sum_ex = acc + pp;

    // The approximate adder splits at column K; the degenerate widths
    // collapse to a plain add (K=0) or a pure OR (K covers every column).
    generate
        if (K == 0) begin : g_k0
            assign sum_ap = sum_ex;
        end else if (K >= PW) begin : g_kall
            assign sum_ap = acc | pp;
        end else begin : g_split
            assign sum_ap = {acc[PW-1:K] + pp[PW-1:K],
                             acc[K-1:0] | pp[K-1:0]};
        end
    endgenerate

    assign acc_next = mode_reg ? sum_ap : sum_ex;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            res_q    <= '0;
            res_ap_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                a_reg    <= a;
                b_reg    <= b;
                mode_reg <= approx_en;
                acc      <= '0;
                cnt      <= '0;
            end
            if (state_q == BUSY) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
                // Result register keeps the last product visible across
                // the following operation's accumulation.
                if (cnt == LAST) begin
                    res_q    <= acc_next;
                    res_ap_q <= mode_reg;
                end
            end
        end
    end

    assign result        = res_q;
    assign result_approx = res_ap_q;

endmodule
